// File: rtl/dmem_if.sv
// Processor data-port bus: processor drives address/data/op, responder returns read data and stall.
interface dmem_if #(
  parameter int unsigned WORD_SIZE = 16
);
  logic [WORD_SIZE-1:0] DataAddr;
  logic [WORD_SIZE-1:0] DataOut;
  logic                 ReadData;
  logic                 WriteData;
  logic [WORD_SIZE-1:0] DataIn;
  logic                 DataWaitreq;
  logic                 ProtoErr;

  modport master (
    output DataAddr, DataOut, ReadData, WriteData,
    input  DataIn, DataWaitreq, ProtoErr
  );

  modport slave (
    input  DataAddr, DataOut, ReadData, WriteData,
    output DataIn, DataWaitreq, ProtoErr
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: word-addressed RAM behind a fixed-latency DataWaitreq stall.
// Optional sticky protocol checker enabled by defining DMEM_PROTOCOL_CHECK_EN.
module dmem_responder #(
  parameter int unsigned WORD_SIZE = 16,
  parameter int unsigned ADDR_BITS = 8,
  parameter int unsigned LATENCY   = 2
) (
  input  logic  Clock,
  input  logic  Reset,
  dmem_if.slave bus
);
  localparam int unsigned CNT_W = 4;
  localparam int unsigned DEPTH = 2 ** ADDR_BITS;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t               r_state, w_state_next;
  logic [CNT_W-1:0]     r_cnt, w_cnt_next;
  logic [ADDR_BITS-1:0] r_addr;
  logic                 r_op_wr;
  logic [WORD_SIZE-1:0] r_wdata;
  logic [WORD_SIZE-1:0] r_data_in;
  logic [WORD_SIZE-1:0] r_mem [DEPTH];

  logic                 w_req, w_none, w_latch, w_commit, w_waitreq;
  logic [ADDR_BITS-1:0] w_acc_addr;
  logic                 w_acc_wr;
  logic [WORD_SIZE-1:0] w_acc_wdata;

  assign w_req  = bus.ReadData ^ bus.WriteData;
  assign w_none = !bus.ReadData && !bus.WriteData;

  // With LATENCY==1 the access commits on the request edge, so it uses the live fields.
  assign w_acc_addr  = (r_state == IDLE) ? bus.DataAddr[ADDR_BITS-1:0] : r_addr;
  assign w_acc_wr    = (r_state == IDLE) ? bus.WriteData : r_op_wr;
  assign w_acc_wdata = (r_state == IDLE) ? bus.DataOut : r_wdata;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_latch      = 1'b0;
    w_commit     = 1'b0;
    w_waitreq    = 1'b0;
    case (r_state)
      IDLE: begin
        w_waitreq = w_req;
        if (w_req) begin
          w_latch = 1'b1;
          if (LATENCY == 1) begin
            w_state_next = DONE;
            w_commit     = 1'b1;
          end else begin
            w_state_next = WAIT;
            w_cnt_next   = CNT_W'(LATENCY - 2);
          end
        end
      end
      WAIT: begin
        w_waitreq = 1'b1;
        if (w_none) begin
          w_state_next = IDLE;
        end else if (r_cnt == '0) begin
          w_state_next = DONE;
          w_commit     = 1'b1;
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_op_wr <= 1'b0;
      r_wdata <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_latch) begin
        r_addr  <= bus.DataAddr[ADDR_BITS-1:0];
        r_op_wr <= bus.WriteData;
        r_wdata <= bus.DataOut;
      end
    end
  end

  // RAM is intentionally not reset; a reset edge suppresses any pending commit.
  always_ff @(posedge Clock) begin
    if (!Reset && w_commit && w_acc_wr) begin
      r_mem[w_acc_addr] <= w_acc_wdata;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_data_in <= '0;
    end else if (w_commit && !w_acc_wr) begin
      r_data_in <= r_mem[w_acc_addr];
    end
  end

  assign bus.DataIn      = r_data_in;
  assign bus.DataWaitreq = w_waitreq;

  generate
    if (ADDR_BITS < WORD_SIZE) begin : g_addr_hi
      logic w_addr_hi_unused;
      assign w_addr_hi_unused = ^bus.DataAddr[WORD_SIZE-1:ADDR_BITS];
    end
  endgenerate

`ifdef DMEM_PROTOCOL_CHECK_EN
  logic r_proto_err;
  logic w_proto_viol;

  assign w_proto_viol = (bus.ReadData && bus.WriteData) ||
                        ((r_state == WAIT) &&
                         (w_none ||
                          (bus.DataAddr[ADDR_BITS-1:0] != r_addr) ||
                          (bus.WriteData != r_op_wr) ||
                          (r_op_wr && (bus.DataOut != r_wdata))));

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_proto_err <= 1'b0;
    end else if (w_proto_viol) begin
      r_proto_err <= 1'b1;
    end
  end

  assign bus.ProtoErr = r_proto_err;
`else
  assign bus.ProtoErr = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: LATENCY=2 and LATENCY=1 instances against an array memory model.
module tb_dmem_responder;
  localparam int unsigned WS = 16;
  localparam int unsigned AB = 8;
`ifdef DMEM_PROTOCOL_CHECK_EN
  localparam logic EXP_PE = 1'b1;
`else
  localparam logic EXP_PE = 1'b0;
`endif

  typedef struct {
    logic [15:0] data;
    int          done_cyc;
  } exp_t;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  int   cyc   = 0;

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  dmem_if #(.WORD_SIZE(WS)) bus2 ();
  dmem_if #(.WORD_SIZE(WS)) bus1 ();

  dmem_responder #(.WORD_SIZE(WS), .ADDR_BITS(AB), .LATENCY(2)) u_dut2 (
    .Clock(Clock), .Reset(Reset), .bus(bus2)
  );
  dmem_responder #(.WORD_SIZE(WS), .ADDR_BITS(AB), .LATENCY(1)) u_dut1 (
    .Clock(Clock), .Reset(Reset), .bus(bus1)
  );

  exp_t        q2[$];
  exp_t        q1[$];
  exp_t        e1, e2;
  logic [15:0] mem_m [2][256];
  logic [15:0] last_rd [2];
  int          n_cmp  = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_bus(input bit sel, input logic rd, input logic wr,
                         input logic [15:0] addr, input logic [15:0] data);
    if (sel) begin
      bus1.ReadData = rd; bus1.WriteData = wr; bus1.DataAddr = addr; bus1.DataOut = data;
    end else begin
      bus2.ReadData = rd; bus2.WriteData = wr; bus2.DataAddr = addr; bus2.DataOut = data;
    end
  endtask

  function automatic logic wait_of(input bit sel);
    return sel ? bus1.DataWaitreq : bus2.DataWaitreq;
  endfunction

  // Called at posedge+1 of an idle cycle; mode 0 normal, 1 drop in WAIT, 2 change address to alt in WAIT.
  task automatic access(input bit sel, input bit wr, input logic [15:0] addr,
                        input logic [15:0] wdata, input int gap, input int mode,
                        input logic [15:0] alt);
    int         lat;
    logic [7:0] a;
    exp_t       e;
    bit         done;
    lat  = sel ? 1 : 2;
    a    = addr[7:0];
    done = 1'b0;
    set_bus(sel, !wr, wr, addr, wdata);
    if (mode != 1) begin
      if (wr) begin
        e.data = last_rd[sel];
        mem_m[sel][a] = wdata;
      end else begin
        e.data = mem_m[sel][a];
        last_rd[sel] = e.data;
      end
      e.done_cyc = cyc + lat;
      if (sel) q1.push_back(e);
      else     q2.push_back(e);
    end
    if (mode == 1) begin
      @(posedge Clock); #1;
      set_bus(sel, 1'b0, 1'b0, 16'h0, 16'h0);
      @(posedge Clock); #1;
    end else begin
      if (mode == 2) begin
        @(posedge Clock); #1;
        set_bus(sel, 1'b1, 1'b0, alt, wdata);
      end
      for (int k = 0; k < 40 && !done; k++) begin
        @(negedge Clock);
        if (!wait_of(sel)) done = 1'b1;
      end
      if (!done) begin
        n_cmp++;
        n_fail++;
        $display("FAIL timeout: DataWaitreq still 1 after 40 cycles, required 0 (dut lat %0d)", lat);
      end
      @(posedge Clock); #1;
      set_bus(sel, 1'b0, 1'b0, 16'h0, 16'h0);
    end
    repeat (gap) begin
      @(posedge Clock); #1;
    end
  endtask

  task automatic reset_pulse();
    Reset = 1'b1;
    set_bus(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    set_bus(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    @(posedge Clock); #1;
    @(posedge Clock); #1;
    Reset = 1'b0;
    last_rd[0] = 16'h0;
    last_rd[1] = 16'h0;
    @(negedge Clock);
    check("reset_clears_proto", 32'(bus2.ProtoErr), 32'(1'b0));
    @(posedge Clock); #1;
  endtask

  // Monitors: a response is the first non-stalled cycle after a stalled cycle that carried a live request.
  logic p_wait2 = 1'b0, p_req2 = 1'b0, p_rst2 = 1'b1;
  logic p_wait1 = 1'b0, p_req1 = 1'b0, p_rst1 = 1'b1;

  always @(negedge Clock) begin
    if (!Reset && !p_rst2 && p_wait2 && p_req2 && !bus2.DataWaitreq) begin
      if (q2.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL lat2_unexpected: response with DataIn %h, required none pending", bus2.DataIn);
      end else begin
        e2 = q2.pop_front();
        check("lat2_data", 32'(bus2.DataIn), 32'(e2.data));
        check("lat2_done_cycle", 32'(cyc), 32'(e2.done_cyc));
      end
    end
    p_wait2 <= bus2.DataWaitreq;
    p_req2  <= bus2.ReadData ^ bus2.WriteData;
    p_rst2  <= Reset;
  end

  always @(negedge Clock) begin
    if (!Reset && !p_rst1 && p_wait1 && p_req1 && !bus1.DataWaitreq) begin
      if (q1.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL lat1_unexpected: response with DataIn %h, required none pending", bus1.DataIn);
      end else begin
        e1 = q1.pop_front();
        check("lat1_data", 32'(bus1.DataIn), 32'(e1.data));
        check("lat1_done_cycle", 32'(cyc), 32'(e1.done_cyc));
      end
    end
    p_wait1 <= bus1.DataWaitreq;
    p_req1  <= bus1.ReadData ^ bus1.WriteData;
    p_rst1  <= Reset;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] old_v;
    set_bus(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    set_bus(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    last_rd[0] = 16'h0;
    last_rd[1] = 16'h0;

    repeat (3) @(posedge Clock);
    @(negedge Clock);
    check("rst_waitreq2", 32'(bus2.DataWaitreq), 32'(1'b0));
    check("rst_datain2",  32'(bus2.DataIn),      32'(16'h0));
    check("rst_proto2",   32'(bus2.ProtoErr),    32'(1'b0));
    check("rst_waitreq1", 32'(bus1.DataWaitreq), 32'(1'b0));
    check("rst_datain1",  32'(bus1.DataIn),      32'(16'h0));
    check("rst_proto1",   32'(bus1.ProtoErr),    32'(1'b0));
    @(posedge Clock); #1;
    Reset = 1'b0;

    // Fill the whole LATENCY=2 RAM so every later read has a known expectation.
    for (int i = 0; i < 256; i++)
      access(1'b0, 1'b1, {8'($urandom), 8'(i)}, 16'($urandom), 0, 0, 16'h0);

    access(1'b0, 1'b1, 16'h0005, 16'hBEEF, 0, 0, 16'h0);
    access(1'b0, 1'b0, 16'h0005, 16'h0,    1, 0, 16'h0);
    access(1'b0, 1'b1, 16'h0103, 16'h1234, 0, 0, 16'h0);
    access(1'b0, 1'b0, 16'h0003, 16'h0,    0, 0, 16'h0);

    for (int i = 0; i < 150; i++)
      access(1'b0, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
             int'($urandom_range(0, 2)), 0, 16'h0);

    // LATENCY=1 instance: known low addresses, back-to-back reads, then random mix.
    for (int i = 0; i < 16; i++)
      access(1'b1, 1'b1, 16'(i), 16'($urandom), 0, 0, 16'h0);
    access(1'b1, 1'b0, 16'h0000, 16'h0, 0, 0, 16'h0);
    access(1'b1, 1'b0, 16'h0001, 16'h0, 0, 0, 16'h0);
    for (int i = 0; i < 30; i++)
      access(1'b1, 1'($urandom_range(0, 1)), {8'($urandom), 4'h0, 4'($urandom)},
             16'($urandom), int'($urandom_range(0, 2)), 0, 16'h0);

    @(negedge Clock);
    check("clean_proto2", 32'(bus2.ProtoErr), 32'(1'b0));
    check("clean_proto1", 32'(bus1.ProtoErr), 32'(1'b0));
    @(posedge Clock); #1;

    // Dropped write must not commit.
    old_v = mem_m[0][7];
    access(1'b0, 1'b1, 16'h0007, ~old_v, 0, 1, 16'h0);
    access(1'b0, 1'b0, 16'h0007, 16'h0,  0, 0, 16'h0);
    @(negedge Clock);
    check("abort_proto", 32'(bus2.ProtoErr), 32'(EXP_PE));
    @(posedge Clock); #1;
    reset_pulse();

    // Address change mid-WAIT: data still comes from the latched address.
    access(1'b0, 1'b1, 16'h0004, 16'h4444, 0, 0, 16'h0);
    access(1'b0, 1'b1, 16'h0009, 16'h9999, 0, 0, 16'h0);
    access(1'b0, 1'b0, 16'h0004, 16'h0,    0, 2, 16'h0009);
    @(negedge Clock);
    check("midwait_proto", 32'(bus2.ProtoErr), 32'(EXP_PE));
    @(posedge Clock); #1;
    reset_pulse();

    // Both ops high: no request, no stall, no RAM write.
    set_bus(1'b0, 1'b1, 1'b1, 16'h0020, ~mem_m[0][8'h20]);
    @(negedge Clock);
    check("both_waitreq", 32'(bus2.DataWaitreq), 32'(1'b0));
    @(posedge Clock); #1;
    set_bus(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge Clock);
    check("both_proto", 32'(bus2.ProtoErr), 32'(EXP_PE));
    @(posedge Clock); #1;
    access(1'b0, 1'b0, 16'h0020, 16'h0, 0, 0, 16'h0);

    // Reset during WAIT of a write: access abandoned, word untouched.
    old_v = mem_m[0][8'h30];
    set_bus(1'b0, 1'b0, 1'b1, 16'h0030, ~old_v);
    @(posedge Clock); #1;
    Reset = 1'b1;
    set_bus(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    @(posedge Clock); #1;
    last_rd[0] = 16'h0;
    last_rd[1] = 16'h0;
    @(negedge Clock);
    check("rstwait_waitreq", 32'(bus2.DataWaitreq), 32'(1'b0));
    check("rstwait_datain",  32'(bus2.DataIn),      32'(16'h0));
    check("rstwait_proto",   32'(bus2.ProtoErr),    32'(1'b0));
    @(posedge Clock); #1;
    Reset = 1'b0;
    @(posedge Clock); #1;
    access(1'b0, 1'b0, 16'h0030, 16'h0, 0, 0, 16'h0);

    repeat (3) @(posedge Clock);
    check("drained_q2", 32'(q2.size()), 32'(0));
    check("drained_q1", 32'(q1.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the pipelined processor's data port: the slave end of the DataAddr/DataOut/DataIn/ReadData/WriteData/DataWaitreq handshake the processor drives from its Memory stage. Holds a word-addressed synchronous RAM and delays every access by a programmable latency, stretching the processor's stall through DataWaitreq. Sits beside the processor in the top level; the instruction port is served separately.

## Interface
- WORD_SIZE, 16, data word width
- ADDR_BITS, 8, RAM depth is 2**ADDR_BITS words; DataAddr bits above ADDR_BITS-1 ignored (address wraps)
- LATENCY, 2, cycles from request to data; legal 1..15
- Clock  in  1  system clock, rising edge
- Reset  in  1  reset, synchronous, active-high
- DataAddr  in  WORD_SIZE  word address from processor
- DataOut  in  WORD_SIZE  write data from processor
- ReadData  in  1  read request
- WriteData  in  1  write request
- DataIn  out  WORD_SIZE  read data to processor, registered
- DataWaitreq  out  1  stall request to processor, combinational
- ProtoErr  out  1  sticky protocol-violation flag (see Configuration)

## Operation
- Request = exactly one of ReadData/WriteData high. Both high: not a request; DataWaitreq=0, no RAM access, state unchanged.
- States: IDLE, WAIT, DONE. Counter cnt, 4 bits.
- IDLE: DataWaitreq = request. On request latch addr[ADDR_BITS-1:0], op, wdata; go DONE if LATENCY==1, else WAIT with cnt=LATENCY-2.
- WAIT: DataWaitreq=1. Request dropped (both low) -> abort to IDLE, nothing committed. Else cnt==0 -> DONE, else cnt-1.
- On the edge entering DONE: read -> DataIn <= mem[addr]; write -> mem[addr] <= wdata. Read uses pre-write contents (only one op per access anyway).
- DONE: DataWaitreq=0, DataIn valid; unconditionally -> IDLE. A request seen in the following IDLE cycle is a new access.
- DataIn holds its last read value otherwise; writes do not change it.
- RAM contents not reset. Reset: state IDLE, cnt 0, DataIn 0, DataWaitreq 0, ProtoErr 0, latched fields 0. Reset mid-access aborts it; a pending write is not committed.

## Timing
- Request first seen cycle t: DataWaitreq high cycles t..t+LATENCY-1, low in t+LATENCY (DONE), DataIn valid in t+LATENCY.
- Back-to-back: next request earliest at t+LATENCY+1; throughput one access per LATENCY+1 cycles.
- Processor must hold DataAddr/op/DataOut stable while DataWaitreq high; responder uses latched copies, so mid-wait changes do not alter the access.
- Write data visible to a read starting the cycle after DONE.

## Configuration
- DMEM_PROTOCOL_CHECK_EN defined: ProtoErr set (sticky until Reset) when ReadData and WriteData both high in any cycle, or in WAIT when DataAddr, op or (write) DataOut differs from the latched copy, or when a request is dropped mid-WAIT.
- Not defined: ProtoErr tied 0, no comparison logic; functional behaviour identical.

## Test plan
- LATENCY=2: write 0xBEEF to addr 5 then read addr 5 -> DataWaitreq high 2 cycles per access, DataIn=0xBEEF in read DONE cycle.
- LATENCY=1: read held one extra cycle -> DataWaitreq high exactly one cycle, data valid next cycle; back-to-back reads of addrs 0,1 complete 2 cycles apart.
- Write 0x1234 to addr 0x0103 with ADDR_BITS=8, read addr 0x03 -> 0x1234 (wrap).
- Write to addr 7, deassert request in WAIT, then read addr 7 -> old contents, no commit; ProtoErr=1 with macro, 0 without.
- Change DataAddr 4->9 mid-WAIT on read -> data returned from addr 4; ProtoErr=1 with macro.
- Assert Reset in WAIT of a write -> DataWaitreq 0 next cycle, state IDLE, DataIn 0, target word unchanged.
